// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous digit updates.
// Optional SEG_BRIGHTNESS_EN macro adds brightness_i[3:0] anode duty control.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid_i,
    output logic                    upd_ready_o,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
`ifdef SEG_BRIGHTNESS_EN
    input  logic [3:0]              brightness_i,
`endif
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_done_o
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic             POL     = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic [DIG_W-1:0]      active_digits;
    logic [NUM_DIGITS-1:0] active_blank;
    logic [DIG_W-1:0]      pend_digits;
    logic [NUM_DIGITS-1:0] pend_blank;

    logic                  slot_end;
    logic                  frame_wrap;
    logic                  xfer;
    logic                  lit;
    logic                  duty_ok;
    logic [3:0]            nibble;
    logic [6:0]            seg_hi;
    logic [NUM_DIGITS-1:0] an_hi;

    // Hex to {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] decode(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan position, handshake and next display values.
    always_comb begin
        slot_end   = (div_cnt == CNT_MAX);
        frame_wrap = slot_end && (digit_idx == IDX_MAX);
        xfer       = upd_valid_i && upd_ready_o;
        nibble     = active_digits[{digit_idx, 2'b00} +: 4];
        // First cycle of every slot is dark so the previous digit cannot ghost.
        lit        = (div_cnt != '0) && !active_blank[digit_idx];
`ifdef SEG_BRIGHTNESS_EN
        duty_ok    = ((CNT_W+6)'(div_cnt) << 4) <
                     ((CNT_W+6)'({1'b0, brightness_i} + 5'd1) * (CNT_W+6)'(REFRESH_DIV));
`else
        duty_ok    = 1'b1;
`endif
        seg_hi     = '0;
        an_hi      = '0;
        if (lit) begin
            seg_hi = decode(nibble);
            if (duty_ok) begin
                an_hi = NUM_DIGITS'(1) << digit_idx;
            end
        end
    end

    // Refresh divider and digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            div_cnt   <= '0;
            digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            div_cnt   <= div_cnt + CNT_W'(1);
        end
    end

    // Pending slot is filled by the handshake and drained only at frame wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_digits <= '0;
            active_blank  <= '1;
            pend_digits   <= '0;
            pend_blank    <= '0;
            upd_ready_o   <= 1'b1;
        end else if (frame_wrap && !upd_ready_o) begin
            active_digits <= pend_digits;
            active_blank  <= pend_blank;
            upd_ready_o   <= 1'b1;
        end else if (xfer) begin
            pend_digits   <= digits_i;
            pend_blank    <= blank_i;
            upd_ready_o   <= 1'b0;
        end
    end

    // Registered pin drivers, polarity applied last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_o        <= {7{POL}};
            an_o         <= {NUM_DIGITS{POL}};
            frame_done_o <= 1'b0;
        end else begin
            seg_o        <= seg_hi ^ {7{POL}};
            an_o         <= an_hi ^ {NUM_DIGITS{POL}};
            frame_done_o <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised self-checking bench for seg_scan_driver against a cycle-count display model.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready_o;
    logic [15:0] digits = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_done_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: cycle count since reset, active and pending display contents.
    int          m_t;
    logic [15:0] m_ad, m_pd;
    logic [3:0]  m_ab, m_pb;
    bit          m_pv;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;
    logic        m_done;
    logic [6:0]  dec_tab [16];

    seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_valid_i  (upd_valid),
        .upd_ready_o  (upd_ready_o),
        .digits_i     (digits),
        .blank_i      (blank),
`ifdef SEG_BRIGHTNESS_EN
        .brightness_i (4'd15),
`endif
        .seg_o        (seg_o),
        .an_o         (an_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model evaluates the rules from the cycle number.
    task automatic cycle();
        int  div, idx;
        bit  pv;
        @(posedge clk);
        if (!rst_n) begin
            m_t = 0; m_ad = '0; m_ab = 4'hF; m_pv = 0; m_pd = '0; m_pb = '0;
            m_seg = 7'h7F; m_an = 4'hF; m_done = 1'b0;
        end else begin
            div = m_t % RD;
            idx = (m_t / RD) % ND;
            if (div == 0 || m_ab[idx]) begin
                m_seg = 7'h7F;
                m_an  = 4'hF;
            end else begin
                m_seg = ~dec_tab[m_ad[4*idx +: 4]];
                m_an  = ~(4'b0001 << idx);
            end
            m_done = ((m_t % FRAME) == FRAME - 1);
            pv = m_pv;
            if (m_done && pv) begin
                m_ad = m_pd; m_ab = m_pb; m_pv = 0;
            end
            if (upd_valid && !pv) begin
                m_pd = digits; m_pb = blank; m_pv = 1;
            end
            m_t++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        n_tests++;
        if ({an_o, seg_o} !== {4'hF, 7'h7F}) begin
            n_fail++;
            $display("FAIL reset_pins got an=%h seg=%h exp an=F seg=7F", an_o, seg_o);
        end
        n_tests++;
        if ({upd_ready_o, frame_done_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_hs got ready=%b done=%b exp ready=1 done=0", upd_ready_o, frame_done_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_frame();
        for (int i = 0; i < FRAME + 2; i++) begin
            cycle();
            n_tests++;
            if ({seg_o, an_o, upd_ready_o, frame_done_o} !== {m_seg, m_an, ~m_pv, m_done}) begin
                n_fail++;
                $display("FAIL first_frame t=%0d got %h exp %h", m_t,
                         {seg_o, an_o, upd_ready_o, frame_done_o}, {m_seg, m_an, ~m_pv, m_done});
            end
            if (an_o != 4'hF) begin
                n_tests++;
                if (seg_o !== 7'h40) begin
                    n_fail++;
                    $display("FAIL zero_digit got seg=%h exp 40", seg_o);
                end
            end
        end
    endtask

    task automatic test_update();
        int  guard;
        while ((m_t % FRAME) != 6) cycle();
        upd_valid = 1'b1; digits = 16'h1A9F; blank = 4'h0;
        cycle();
        upd_valid = 1'b0;
        n_tests++;
        if (upd_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL upd_ready_drop got %b exp 0", upd_ready_o);
        end
        guard = 0;
        do begin
            cycle();
            guard++;
            n_tests++;
            if ({seg_o, an_o, upd_ready_o, frame_done_o} !== {m_seg, m_an, ~m_pv, m_done}) begin
                n_fail++;
                $display("FAIL update_wait t=%0d got %h exp %h", m_t,
                         {seg_o, an_o, upd_ready_o, frame_done_o}, {m_seg, m_an, ~m_pv, m_done});
            end
        end while (frame_done_o !== 1'b1 && guard < 3 * FRAME);
        n_tests++;
        if (frame_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_done_timeout got %b exp 1", frame_done_o);
        end
        cycle();
        cycle();
        n_tests++;
        if ({an_o, seg_o, upd_ready_o} !== {4'hE, 7'h0E, 1'b1}) begin
            n_fail++;
            $display("FAIL digit0_F got an=%h seg=%h ready=%b exp an=E seg=0E ready=1",
                     an_o, seg_o, upd_ready_o);
        end
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            n_tests++;
            if ({seg_o, an_o} !== {m_seg, m_an}) begin
                n_fail++;
                $display("FAIL new_frame t=%0d got seg=%h an=%h exp seg=%h an=%h",
                         m_t, seg_o, an_o, m_seg, m_an);
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        upd_valid = 1'b1; digits = 16'h5555; blank = 4'h0;
        cycle();
        digits = 16'h2222;
        guard = 0;
        while (!(m_pv && m_pd == 16'h2222) && guard < 3 * FRAME) begin
            cycle();
            guard++;
            n_tests++;
            if ({seg_o, an_o, upd_ready_o, frame_done_o} !== {m_seg, m_an, ~m_pv, m_done}) begin
                n_fail++;
                $display("FAIL backpressure t=%0d got %h exp %h", m_t,
                         {seg_o, an_o, upd_ready_o, frame_done_o}, {m_seg, m_an, ~m_pv, m_done});
            end
        end
        upd_valid = 1'b0;
        n_tests++;
        if (upd_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL second_capture got ready=%b exp 0", upd_ready_o);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            n_tests++;
            if ({seg_o, an_o, upd_ready_o, frame_done_o} !== {m_seg, m_an, ~m_pv, m_done}) begin
                n_fail++;
                $display("FAIL second_show t=%0d got %h exp %h", m_t,
                         {seg_o, an_o, upd_ready_o, frame_done_o}, {m_seg, m_an, ~m_pv, m_done});
            end
        end
    endtask

    task automatic test_blank();
        while (!(upd_ready_o === 1'b1 && (m_t % FRAME) == 3)) cycle();
        upd_valid = 1'b1; digits = 16'h8888; blank = 4'b0101;
        cycle();
        upd_valid = 1'b0;
        while ((m_t % FRAME) != 0) cycle();
        cycle();
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            n_tests++;
            if ({seg_o, an_o} !== {m_seg, m_an}) begin
                n_fail++;
                $display("FAIL blank_model t=%0d got seg=%h an=%h exp seg=%h an=%h",
                         m_t, seg_o, an_o, m_seg, m_an);
            end
            if (an_o != 4'hF) begin
                n_tests++;
                if (!(an_o == 4'hD || an_o == 4'h7) || seg_o !== 7'h00) begin
                    n_fail++;
                    $display("FAIL blank_slots got an=%h seg=%h exp an=D/7 seg=00", an_o, seg_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        while (!(upd_ready_o === 1'b1 && (m_t % FRAME) == 5)) cycle();
        upd_valid = 1'b1; digits = 16'h3333; blank = 4'h0;
        cycle();
        upd_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_tests++;
        if ({an_o, seg_o, upd_ready_o, frame_done_o} !== {4'hF, 7'h7F, 2'b10}) begin
            n_fail++;
            $display("FAIL mid_reset got an=%h seg=%h ready=%b done=%b exp F 7F 1 0",
                     an_o, seg_o, upd_ready_o, frame_done_o);
        end
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            cycle();
            n_tests++;
            if ({seg_o, an_o, upd_ready_o, frame_done_o} !== {m_seg, m_an, ~m_pv, m_done}) begin
                n_fail++;
                $display("FAIL after_reset t=%0d got %h exp %h", m_t,
                         {seg_o, an_o, upd_ready_o, frame_done_o}, {m_seg, m_an, ~m_pv, m_done});
            end
            if (i < 2 && an_o !== 4'hF) begin
                n_fail++;
                $display("FAIL restart_idx got an=%h exp F", an_o);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            upd_valid = ($urandom_range(3) == 0);
            digits    = 16'($urandom);
            blank     = 4'($urandom);
            rst_n     = ($urandom_range(199) != 0);
            cycle();
            n_tests++;
            if ({seg_o, an_o, upd_ready_o, frame_done_o} !== {m_seg, m_an, ~m_pv, m_done}) begin
                n_fail++;
                $display("FAIL random t=%0d got %h exp %h", m_t,
                         {seg_o, an_o, upd_ready_o, frame_done_o}, {m_seg, m_an, ~m_pv, m_done});
            end
        end
        upd_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        @(negedge clk);
        test_reset();
        test_first_frame();
        test_update();
        test_back_to_back();
        test_blank();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
